// File: rtl/sar_pkg.sv
// Shared definitions for the SAR result path: default code width, FSM encoding and
// the code-integrity rule used by the datapath and by anything modelling it.
package sar_pkg;

    localparam int SAR_NBITS = 5;
    localparam int SAR_WMAX  = 16;

    typedef enum logic [1:0] {
        ACC  = 2'd0,
        FULL = 2'd1
    } sar_state_t;

    // A finished code is good when every bit was decided exactly once: P and N disjoint and covering.
    function automatic logic sar_code_ok(input logic [SAR_WMAX-1:0] p,
                                         input logic [SAR_WMAX-1:0] n,
                                         input int                  nbits);
        logic [SAR_WMAX-1:0] mask;
        mask = '0;
        for (int i = 0; i < SAR_WMAX; i++) begin
            if (i < nbits) mask[i] = 1'b1;
        end
        return ((p & n) == '0) && ((p | n) == mask);
    endfunction

endpackage

// File: rtl/sar_code_check.sv
// Combinational integrity check of one SAR code; the good code value is the positive decisions.
module sar_code_check
    import sar_pkg::*;
#(
    parameter int NBITS = SAR_NBITS
) (
    input  logic [NBITS-1:0] RESULTP,
    input  logic [NBITS-1:0] RESULTN,
    output logic             GOOD,
    output logic [NBITS-1:0] CODE
);

    assign GOOD = sar_code_ok(SAR_WMAX'(RESULTP), SAR_WMAX'(RESULTN), NBITS);
    assign CODE = RESULTP;

endmodule

// File: rtl/sar_result_avg.sv
// Averages 2**LOG2AVG good SAR codes and presents the mean on a valid/ready port,
// with a sticky overrun flag and a saturating count of rejected codes.
module sar_result_avg
    import sar_pkg::*;
#(
    parameter int NBITS   = SAR_NBITS,
    parameter int LOG2AVG = 2,
    parameter int ERRW    = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             CLR,
    input  logic             VALID_IN,
    input  logic [NBITS-1:0] RESULTP,
    input  logic [NBITS-1:0] RESULTN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [NBITS-1:0] OUT_DATA,
    output logic             OVERRUN,
    output logic [ERRW-1:0]  ERR_CNT
);

    localparam int             AW   = NBITS + LOG2AVG;
    localparam int             CW   = (LOG2AVG > 0) ? LOG2AVG : 1;
    localparam logic [CW-1:0]  LAST = CW'((1 << LOG2AVG) - 1);

    logic             good;
    logic [NBITS-1:0] code;
    logic [AW-1:0]    acc;
    logic [AW-1:0]    sum;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             bad;
    logic             mean_done;
    logic [NBITS-1:0] mean;
    logic             load;
    logic             drop;
    sar_state_t       state;
    sar_state_t       state_nxt;

    sar_code_check #(.NBITS(NBITS)) u_check (
        .RESULTP (RESULTP),
        .RESULTN (RESULTN),
        .GOOD    (good),
        .CODE    (code)
    );

    assign accept    = EN & VALID_IN & good;
    assign bad       = EN & VALID_IN & ~good;
    assign sum       = acc + AW'(code);
    assign mean_done = accept && (cnt == LAST);
    assign mean      = NBITS'(sum >> LOG2AVG);

    // Output handshake: a word transfers on a cycle where OUT_VALID and OUT_READY are both 1;
    // OUT_DATA is held while OUT_VALID=1 and not yet taken, and a transfer may coincide with a new load.
    assign OUT_VALID = (state == FULL);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        drop      = 1'b0;
        case (state)
            ACC: begin
                if (mean_done) begin
                    load      = 1'b1;
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (mean_done) begin
                    if (OUT_READY) load = 1'b1;
                    else           drop = 1'b1;
                end else if (OUT_READY) begin
                    state_nxt = ACC;
                end
            end
            default: state_nxt = ACC;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ACC;
            OUT_DATA <= '0;
            acc      <= '0;
            cnt      <= '0;
            OVERRUN  <= 1'b0;
            ERR_CNT  <= '0;
        end else begin
            state <= state_nxt;
            if (load) OUT_DATA <= mean;

            // Disabling throws away any partial average so re-enabling starts clean.
            if (!EN || mean_done) begin
                acc <= '0;
                cnt <= '0;
            end else if (accept) begin
                acc <= sum;
                cnt <= cnt + CW'(1);
            end

            if (CLR)       OVERRUN <= 1'b0;
            else if (drop) OVERRUN <= 1'b1;

            if (CLR)                        ERR_CNT <= '0;
            else if (bad && ERR_CNT != '1)  ERR_CNT <= ERR_CNT + ERRW'(1);
        end
    end

endmodule
